// File: rtl/mc_fifo_pkg.sv
// mc_fifo_pkg: shared widths, default thresholds and helpers for the
// multi-channel synchronous FIFO (mc_sync_fifo and mc_fifo_ram).
// Optional stored parity is enabled by defining MC_FIFO_PARITY_EN.

package mc_fifo_pkg;

    // Default configuration; the top level takes these as parameter defaults.
    localparam int MC_DATA_WIDTH  = 8;
    localparam int MC_ADDR_WIDTH  = 4;
    localparam int MC_NUM_CH      = 4;
    localparam int MC_DEPTH       = 1 << MC_ADDR_WIDTH;
    localparam int MC_AFULL_LVL   = MC_DEPTH - 2;
    localparam int MC_AEMPTY_LVL  = 2;

    // Pointers carry one extra wrap bit so full and empty are distinguishable;
    // occupancy needs the same width to represent DEPTH itself.
    typedef logic [MC_ADDR_WIDTH:0] ptr_t;
    typedef logic [MC_ADDR_WIDTH:0] cnt_t;

    // Channel-select width; a single channel still needs a 1-bit port.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mc_fifo_ram.sv
// mc_fifo_ram: simple dual-port storage shared by all channels.
// One synchronous write port, one registered read port, no reset on the
// array or the read register (contents are never cleared).

module mc_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [1 << AW];

    // Write port: store the word when the top level accepts a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: capture the addressed word on an accepted read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mc_sync_fifo.sv
// mc_sync_fifo: NUM_CH independent FIFOs of 2^ADDR_WIDTH entries sharing one
// storage array, single clock, asynchronous active-low reset.
// Define MC_FIFO_PARITY_EN to store an even-parity bit per word and report
// par_err on reads; otherwise par_err is tied low.
//
// Handshake: wr_en/rd_en are requests without a ready. A request is accepted
// only if the target channel's registered flag allows it (write: !full,
// read: !empty); a refused request has no side effect other than a one-cycle
// ovf/udf pulse after the edge. An accepted read returns its word on
// rd_data with rd_valid=1 for exactly one cycle after the accepting edge.

module mc_sync_fifo
    import mc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = MC_DATA_WIDTH,
    parameter int ADDR_WIDTH = MC_ADDR_WIDTH,
    parameter int NUM_CH     = MC_NUM_CH,
    parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = MC_AEMPTY_LVL
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ch_w(NUM_CH)-1:0]          wr_ch,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [ch_w(NUM_CH)-1:0]          rd_ch,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic [NUM_CH-1:0]                full,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH-1:0]                afull,
    output logic [NUM_CH-1:0]                aempty,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count,
    output logic                             ovf,
    output logic                             udf,
    output logic                             par_err
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int PW   = ADDR_WIDTH + 1;
    localparam int RAW  = CH_W + ADDR_WIDTH;
`ifdef MC_FIFO_PARITY_EN
    localparam int MW   = DATA_WIDTH + 1;
`else
    localparam int MW   = DATA_WIDTH;
`endif

    localparam logic [PW-1:0] DEPTH_C  = PW'(1 << ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

    logic [PW-1:0] wptr_q [NUM_CH];
    logic [PW-1:0] rptr_q [NUM_CH];
    logic [PW-1:0] cnt_q  [NUM_CH];
    logic [PW-1:0] wptr_d [NUM_CH];
    logic [PW-1:0] rptr_d [NUM_CH];
    logic [PW-1:0] cnt_d  [NUM_CH];

    logic [NUM_CH-1:0] full_q, empty_q, afull_q, aempty_q;
    logic [NUM_CH-1:0] full_d, empty_d, afull_d, aempty_d;

    logic wr_acc, rd_acc;
    logic rd_valid_q, ovf_q, udf_q;

    logic [RAW-1:0] ram_waddr, ram_raddr;
    logic [MW-1:0]  ram_wdata, ram_rdata;

    // Accept decisions and next pointers/occupancy/flags from pre-cycle flags.
    always_comb begin
        wr_acc = wr_en && !full_q[wr_ch];
        rd_acc = rd_en && !empty_q[rd_ch];
        for (int c = 0; c < NUM_CH; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            if (wr_acc && (wr_ch == CH_W'(c))) begin
                wptr_d[c] = wptr_q[c] + PW'(1);
            end
            if (rd_acc && (rd_ch == CH_W'(c))) begin
                rptr_d[c] = rptr_q[c] + PW'(1);
            end
            cnt_d[c]    = wptr_d[c] - rptr_d[c];
            full_d[c]   = (cnt_d[c] == DEPTH_C);
            empty_d[c]  = (cnt_d[c] == '0);
            afull_d[c]  = (cnt_d[c] >= AFULL_C);
            aempty_d[c] = (cnt_d[c] <= AEMPTY_C);
        end
    end

    // Pointer, occupancy and flag registers; reset flushes every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            full_q   <= '0;
            empty_q  <= '1;
            afull_q  <= '0;
            aempty_q <= '1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Read-valid and reject pulses, one cycle after the deciding edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            ovf_q      <= wr_en && full_q[wr_ch];
            udf_q      <= rd_en && empty_q[rd_ch];
        end
    end

    // Physical address is {channel, low pointer bits}; a same-channel read and
    // write never collide because one of them is refused at full or empty.
    always_comb begin
        ram_waddr = {wr_ch, wptr_q[wr_ch][ADDR_WIDTH-1:0]};
        ram_raddr = {rd_ch, rptr_q[rd_ch][ADDR_WIDTH-1:0]};
`ifdef MC_FIFO_PARITY_EN
        ram_wdata = {^wr_data, wr_data};
`else
        ram_wdata = wr_data;
`endif
    end

    mc_fifo_ram #(
        .WIDTH (MW),
        .AW    (RAW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The read register is not reset, so gating by rd_valid gives the 0 value
    // when idle and makes an asynchronous reset drop the payload at once.
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? ram_rdata[DATA_WIDTH-1:0] : '0;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign afull    = afull_q;
    assign aempty   = aempty_q;

`ifdef MC_FIFO_PARITY_EN
    assign par_err = rd_valid_q && ((^ram_rdata[DATA_WIDTH-1:0]) != ram_rdata[DATA_WIDTH]);
`else
    assign par_err = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_count
        assign count[g*PW +: PW] = cnt_q[g];
    end

endmodule

// File: tb/tb_mc_sync_fifo.sv
// tb_mc_sync_fifo: self-checking bench for mc_sync_fifo (default parameters).
// Define MC_FIFO_PARITY_EN for both bench and RTL to include the parity case.

module tb_mc_sync_fifo;
    import mc_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NCH   = 4;
    localparam int DEPTH = 1 << AW;
    localparam int CHW   = 2;
    localparam int PW    = AW + 1;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [CHW-1:0]    wr_ch;
    logic [DW-1:0]     wr_data;
    logic              rd_en;
    logic [CHW-1:0]    rd_ch;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [NCH-1:0]    full, empty, afull, aempty;
    logic [NCH*PW-1:0] count;
    logic              ovf, udf, par_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH),
        .AFULL_LVL  (DEPTH - 2),
        .AEMPTY_LVL (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_ch    (rd_ch),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .aempty   (aempty),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf),
        .par_err  (par_err)
    );

    // ---------------- scoreboard / reference model ----------------
    // One expected queue per channel: the FIFO contents as the reader will see them.
    logic [DW-1:0] exp_q [NCH][$];
    int            n_checks;
    int            n_err;
    logic          exp_par;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flags and occupancy follow directly from each queue's size.
    task automatic check_state(input string tag);
        logic [NCH-1:0]    ef, ee, eaf, eae;
        logic [NCH*PW-1:0] ec;
        for (int c = 0; c < NCH; c++) begin
            int n;
            n = exp_q[c].size();
            ef[c]  = (n == DEPTH);
            ee[c]  = (n == 0);
            eaf[c] = (n >= DEPTH - 2);
            eae[c] = (n <= 2);
            ec[c*PW +: PW] = PW'(n);
        end
        chk({tag, "_full"},   full,   ef);
        chk({tag, "_empty"},  empty,  ee);
        chk({tag, "_afull"},  afull,  eaf);
        chk({tag, "_aempty"}, aempty, eae);
        chk({tag, "_count"},  count,  ec);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drives one cycle of requests, predicts the outcome
    // from the queues, lets the edge happen, then compares at posedge+1.
    task automatic do_cycle(input logic we, input logic [CHW-1:0] wc, input logic [DW-1:0] wd,
                            input logic re, input logic [CHW-1:0] rc);
        logic          wr_ok, rd_ok;
        logic [DW-1:0] exp_d;
        wr_en   = we;
        wr_ch   = wc;
        wr_data = wd;
        rd_en   = re;
        rd_ch   = rc;
        wr_ok = we && (exp_q[wc].size() < DEPTH);
        rd_ok = re && (exp_q[rc].size() > 0);
        exp_d = '0;
        if (rd_ok) exp_d = exp_q[rc].pop_front();
        if (wr_ok) exp_q[wc].push_back(wd);
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid, rd_ok);
        chk("rd_data",  rd_data,  exp_d);
        chk("ovf",      ovf,      we && !wr_ok);
        chk("udf",      udf,      re && !rd_ok);
        chk("par_err",  par_err,  exp_par && rd_ok);
        check_state("cyc");
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_ch   = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic          we;
        logic [CHW-1:0] wc;
        logic [DW-1:0] wd;
        logic          re;
        logic [CHW-1:0] rc;
        logic          ev;
        logic [DW-1:0] ed;
        logic          eo;
        logic          eu;
        logic [CHW-1:0] cc;
        logic [PW-1:0] ec;
    } vec_t;

    vec_t tbl [8];

    initial begin
        n_checks = 0;
        n_err    = 0;
        exp_par  = 1'b0;
        rst_n    = 1'b1;
        idle_inputs();

        //          we    wc    wd     re    rc    ev    ed     eo    eu    cc    ec
        tbl[0] = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 5'd1};
        tbl[1] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd2, 5'd0};
        tbl[2] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 5'd0};
        tbl[3] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 5'd0};
        tbl[4] = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 5'd1};
        tbl[5] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 5'd0};
        tbl[6] = '{1'b1, 2'd1, 8'h3C, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 5'd1};
        tbl[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h3C, 1'b0, 1'b0, 2'd1, 5'd0};

        // Reset: asynchronous assertion before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data",  rd_data,  '0);
        chk("rst_ovf",      ovf,      1'b0);
        chk("rst_udf",      udf,      1'b0);
        chk("rst_par_err",  par_err,  1'b0);
        check_state("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: single-cycle behaviours with constant expectations.
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = tbl[i];
            do_cycle(v.we, v.wc, v.wd, v.re, v.rc);
            chk("tbl_valid", rd_valid, v.ev);
            chk("tbl_data",  rd_data,  v.ed);
            chk("tbl_ovf",   ovf,      v.eo);
            chk("tbl_udf",   udf,      v.eu);
            chk("tbl_count", count[v.cc*PW +: PW], v.ec);
        end

        // Fill ch1 to the brim, then one write too many.
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 2'd1, 8'(i * 7 + 3), 1'b0, 2'd0);
        end
        chk("fill_full1",  full[1], 1'b1);
        chk("fill_count1", count[1*PW +: PW], 5'd16);
        do_cycle(1'b1, 2'd1, 8'hEE, 1'b0, 2'd0);
        chk("fill_ovf",    ovf, 1'b1);
        do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        chk("ovf_once",    ovf, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
            chk("fill_order", rd_data, 8'(i * 7 + 3));
        end
        chk("drain_empty1", empty[1], 1'b1);

        // Same-channel write+read at count 5, then at count 0.
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 2'd0, 8'($urandom), 1'b0, 2'd0);
        end
        do_cycle(1'b1, 2'd0, 8'h77, 1'b1, 2'd0);
        chk("same5_count", count[0 +: PW], 5'd5);
        chk("same5_udf",   udf, 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        end
        do_cycle(1'b1, 2'd0, 8'h42, 1'b1, 2'd0);
        chk("same0_udf",   udf, 1'b1);
        chk("same0_count", count[0 +: PW], 5'd1);
        do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        chk("same0_data",  rd_data, 8'h42);

        // Random ch0/ch3 traffic in write-heavy and read-heavy phases so the
        // queues cross the almost-full/almost-empty levels and pointers wrap.
        for (int i = 0; i < 240; i++) begin
            logic we, re;
            int   wp;
            wp = ((i / 60) % 2 == 0) ? 8 : 3;
            we = ($urandom_range(0, 9) < wp);
            re = ($urandom_range(0, 9) < (11 - wp));
            do_cycle(we, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 8'($urandom),
                     re, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0);
        end

        // Random traffic over all channels.
        for (int i = 0; i < 120; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // Reset in the middle of a burst with a read result on the outputs.
        do_cycle(1'b1, 2'd1, 8'h81, 1'b0, 2'd0);
        do_cycle(1'b1, 2'd1, 8'h82, 1'b1, 2'd1);
        do_cycle(1'b1, 2'd2, 8'h83, 1'b1, 2'd1);
        chk("pre_rst_valid", rd_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        #1;
        chk("mid_rst_valid", rd_valid, 1'b0);
        chk("mid_rst_data",  rd_data,  '0);
        chk("mid_rst_udf",   udf,      1'b0);
        check_state("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0);

`ifdef MC_FIFO_PARITY_EN
        // ch2 pointers are 0 after the reset, so the word sits at address {2, 0}.
        dut.u_ram.mem[32] = dut.u_ram.mem[32] ^ 9'h100;
        exp_par = 1'b1;
        do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        chk("par_err_flip", par_err, 1'b1);
        exp_par = 1'b0;
`else
        do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        chk("post_rst_data", rd_data, 8'h5A);
`endif
        do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
